// File: rtl/dmem_boot_loader.sv
// ---------------------------------------------------------------------------
// dmem_boot_loader
//
// Boot-time owner of the data memory write port. While the CPU is held in
// reset, a host streams (address, word) beats over a valid/ready handshake and
// every aligned, in-window beat is written to data_mem as a full word in the
// same cycle it is accepted. Once the stream ends, either through host_last or
// because the window is full, the CPU stays in reset for RELEASE_DELAY more
// cycles. After that the write port is handed back to the CPU unchanged.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   start_load                  begin a load from IDLE, or restart one from RUN
//   host_valid/ready/addr/
//   host_data/host_last         host beat stream
//   cpu_MemWrite/Store/
//   cpu_DataAdr/cpu_WriteData   CPU store port, passed through only in RUN
//   cpu_reset                   reset to the CPU, low only in RUN
//   MemWrite/Store/DataAdr/
//   WriteData                   data_mem write port
//   busy, done                  status: LOAD or DRAIN / RUN
//   word_count                  words written by the current load
//   err_align, err_range        sticky flags for dropped beats
// ---------------------------------------------------------------------------
module dmem_boot_loader #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          MAX_WORDS     = 64,
    parameter int          COUNT_W       = 16,
    parameter int          RELEASE_DELAY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_load,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [31:0]        host_addr,
    input  logic [31:0]        host_data,
    input  logic               host_last,
    input  logic               cpu_MemWrite,
    input  logic [2:0]         cpu_Store,
    input  logic [31:0]        cpu_DataAdr,
    input  logic [31:0]        cpu_WriteData,
    output logic               cpu_reset,
    output logic               MemWrite,
    output logic [2:0]         Store,
    output logic [31:0]        DataAdr,
    output logic [31:0]        WriteData,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] word_count,
    output logic               err_align,
    output logic               err_range
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    // The window size is held in 33 bits so that a large MAX_WORDS cannot
    // wrap the bound to zero.
    localparam logic [32:0]        WINDOW_BYTES = 33'(4 * MAX_WORDS);
    localparam logic [COUNT_W-1:0] LAST_INDEX   = COUNT_W'(MAX_WORDS - 1);
    localparam logic [31:0]        DRAIN_LAST   = 32'(RELEASE_DELAY - 1);
    localparam logic [2:0]         STORE_WORD   = 3'b010;

    state_t      state;
    logic [31:0] delayCnt;

    logic        handshake;
    logic        aligned;
    logic        inRange;
    logic        writeBeat;
    logic [31:0] offset;

    // Reset takes priority over the handshake. A beat presented during the
    // reset cycle is never written, even though host_ready, which decodes
    // only from the state, still reads 1 in that cycle.
    assign handshake = (state == LOAD) && host_valid && !reset;
    assign aligned   = (host_addr[1:0] == 2'b00);
    assign offset    = host_addr - BASE_ADDR;
    // Unsigned check. The offset is only meaningful once host_addr >= BASE_ADDR.
    assign inRange   = (host_addr >= BASE_ADDR) && ({1'b0, offset} < WINDOW_BYTES);
    assign writeBeat = handshake && aligned && inRange;

    assign cpu_reset  = (state != RUN);
    assign host_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == DRAIN);
    assign done       = (state == RUN);

    // Write port mux. Outside RUN the loader owns the port and cpu_MemWrite
    // is ignored.
    always_comb begin
        MemWrite  = writeBeat;
        Store     = STORE_WORD;
        DataAdr   = host_addr;
        WriteData = host_data;
        if (state == RUN) begin
            MemWrite  = cpu_MemWrite;
            Store     = cpu_Store;
            DataAdr   = cpu_DataAdr;
            WriteData = cpu_WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_count <= '0;
            err_align  <= 1'b0;
            err_range  <= 1'b0;
            delayCnt   <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (start_load) begin
                        state      <= LOAD;
                        word_count <= '0;
                        err_align  <= 1'b0;
                        err_range  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (!aligned) begin
                            err_align <= 1'b1;
                        end else if (!inRange) begin
                            err_range <= 1'b1;
                        end else begin
                            word_count <= word_count + COUNT_W'(1);
                        end
                        // A last beat ends the load even if it was dropped.
                        // A full window also ends it, so the next beat is
                        // never accepted.
                        if (host_last || (writeBeat && word_count == LAST_INDEX)) begin
                            state    <= DRAIN;
                            delayCnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (delayCnt == DRAIN_LAST) begin
                        state <= RUN;
                    end else begin
                        delayCnt <= delayCnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_boot_loader.sv
module tb_dmem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 64;
    localparam int CW   = 16;
    localparam int RD   = 2;

    logic          clk = 1'b0;
    logic          reset, start_load, host_valid, host_last, cpu_MemWrite;
    logic [31:0]   host_addr, host_data, cpu_DataAdr, cpu_WriteData;
    logic [2:0]    cpu_Store;
    logic          host_ready, cpu_reset, MemWrite, busy, done, err_align, err_range;
    logic [2:0]    Store;
    logic [31:0]   DataAdr, WriteData;
    logic [CW-1:0] word_count;

    dmem_boot_loader #(
        .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .COUNT_W(CW), .RELEASE_DELAY(RD)
    ) dut (
        .clk(clk), .reset(reset), .start_load(start_load),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .host_last(host_last),
        .cpu_MemWrite(cpu_MemWrite), .cpu_Store(cpu_Store),
        .cpu_DataAdr(cpu_DataAdr), .cpu_WriteData(cpu_WriteData),
        .cpu_reset(cpu_reset), .MemWrite(MemWrite), .Store(Store),
        .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .done(done),
        .word_count(word_count), .err_align(err_align), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values for the next cycle. step() copies them onto the DUT at the negedge.
    bit          nRst, nSt, nHv, nHl, nCmw;
    logic [31:0] nHa, nHd, nCa, nCw;
    logic [2:0]  nCs;

    // Reference model: load in progress, remaining hold cycles, CPU released.
    bit          mLoading, mRunning, mErrA, mErrR;
    int          mDrainLeft, mCount;
    logic [31:0] expMem [MAXW];
    logic [31:0] dutMem [MAXW];
    int          dutWrites;

    typedef struct {
        bit          rst, st, hv, hl;
        logic [31:0] ha, hd;
        bit          eReset, eReady, eWr, eDone;
        int          eCount;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearNext();
        nRst = 0; nSt = 0; nHv = 0; nHl = 0; nCmw = 0;
        nHa = 0; nHd = 0; nCa = 0; nCw = 0; nCs = 0;
    endtask

    task automatic step(input bit useVec, input vec_t v);
        bit     hs, ok, expWr;
        longint off;
        @(negedge clk);
        reset = nRst; start_load = nSt; host_valid = nHv; host_last = nHl;
        host_addr = nHa; host_data = nHd; cpu_MemWrite = nCmw;
        cpu_Store = nCs; cpu_DataAdr = nCa; cpu_WriteData = nCw;
        #1;
        off   = longint'(host_addr) - longint'(BASE);
        hs    = mLoading && host_valid && !reset;
        ok    = hs && (host_addr % 4 == 0) && off >= 0 && off < 4 * MAXW;
        expWr = mRunning ? cpu_MemWrite : ok;
        chk("cpu_reset", cpu_reset, !mRunning);
        chk("host_ready", host_ready, mLoading);
        chk("busy", busy, mLoading || mDrainLeft > 0);
        chk("done", done, mRunning);
        chk("MemWrite", MemWrite, expWr);
        chk("word_count", 32'(word_count), 32'(mCount));
        chk("err_align", err_align, mErrA);
        chk("err_range", err_range, mErrR);
        if (mRunning) begin
            chk("run_Store", Store, cpu_Store);
            chk("run_DataAdr", DataAdr, cpu_DataAdr);
            chk("run_WriteData", WriteData, cpu_WriteData);
        end else if (expWr) begin
            chk("ld_Store", Store, 3'b010);
            chk("ld_DataAdr", DataAdr, host_addr);
            chk("ld_WriteData", WriteData, host_data);
        end
        if (useVec) begin
            chk("vec_cpu_reset", cpu_reset, v.eReset);
            chk("vec_host_ready", host_ready, v.eReady);
            chk("vec_MemWrite", MemWrite, v.eWr);
            chk("vec_done", done, v.eDone);
            chk("vec_word_count", 32'(word_count), 32'(v.eCount));
        end
        if (MemWrite === 1'b1 && cpu_reset === 1'b1) begin
            dutWrites++;
            if (DataAdr - BASE < 4 * MAXW) dutMem[(DataAdr - BASE) >> 2] = WriteData;
        end
        if (ok) expMem[off / 4] = host_data;
        @(posedge clk);
        if (reset) begin
            mLoading = 0; mRunning = 0; mDrainLeft = 0; mCount = 0; mErrA = 0; mErrR = 0;
        end else if (mRunning || (!mLoading && mDrainLeft == 0)) begin
            if (start_load) begin
                mRunning = 0; mLoading = 1; mCount = 0; mErrA = 0; mErrR = 0;
            end
        end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mRunning = 1;
        end else if (hs) begin
            if (host_addr % 4 != 0) mErrA = 1;
            else if (!ok) mErrR = 1;
            else mCount++;
            if (host_last || (ok && mCount == MAXW)) begin
                mLoading = 0; mDrainLeft = RD;
            end
        end
    endtask

    task automatic cyc();
        vec_t d;
        d = '{default: 0};
        step(0, d);
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit last);
        clearNext(); nHv = 1; nHa = a; nHd = d; nHl = last;
        cyc();
        clearNext();
    endtask

    task automatic startLoad();
        clearNext(); nSt = 1; cyc(); clearNext();
    endtask

    function automatic vec_t mk(bit rst, bit st, bit hv, bit hl, logic [31:0] ha, logic [31:0] hd,
                                bit eReset, bit eReady, bit eWr, bit eDone, int eCount);
        vec_t v;
        v.rst = rst; v.st = st; v.hv = hv; v.hl = hl; v.ha = ha; v.hd = hd;
        v.eReset = eReset; v.eReady = eReady; v.eWr = eWr; v.eDone = eDone; v.eCount = eCount;
        return v;
    endfunction

    initial begin
        // Normal three-beat load with one gap. The last handshake is at row 5,
        // so the CPU is released at row 8.
        tbl[0] = mk(1, 0, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 1, 0, 32'h0, 32'hAAAA0001,  1, 1, 1, 0, 0);
        tbl[3] = mk(0, 0, 1, 0, 32'h4, 32'hAAAA0002,  1, 1, 1, 0, 1);
        tbl[4] = mk(0, 0, 0, 0, 32'h8, 32'h0,         1, 1, 0, 0, 2);
        tbl[5] = mk(0, 0, 1, 1, 32'h8, 32'hAAAA0003,  1, 1, 1, 0, 2);
        tbl[6] = mk(0, 0, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 3);
        tbl[7] = mk(0, 0, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 3);
        tbl[8] = mk(0, 0, 0, 0, 32'h0, 32'h0,         0, 0, 0, 1, 3);

        for (int i = 0; i < MAXW; i++) begin
            expMem[i] = 0; dutMem[i] = 0;
        end
        clearNext();
        reset = 1; start_load = 0; host_valid = 0; host_last = 0; host_addr = 0;
        host_data = 0; cpu_MemWrite = 0; cpu_Store = 0; cpu_DataAdr = 0; cpu_WriteData = 0;
        mLoading = 0; mRunning = 0; mDrainLeft = 0; mCount = 0; mErrA = 0; mErrR = 0;
        repeat (2) @(posedge clk);
        dutWrites = 0;

        for (int i = 0; i < 9; i++) begin
            clearNext();
            nRst = tbl[i].rst; nSt = tbl[i].st; nHv = tbl[i].hv; nHl = tbl[i].hl;
            nHa = tbl[i].ha; nHd = tbl[i].hd;
            step(1, tbl[i]);
        end
        clearNext();
        #2 chk("normal_writes", dutWrites, 3);

        // Backpressure: valid goes 1,0,1 and the second beat is last.
        startLoad();
        dutWrites = 0;
        beat(32'h20, 32'h1111_0001, 0);
        cyc();
        beat(32'h24, 32'h1111_0002, 1);
        repeat (3) cyc();
        #2 chk("bp_writes", dutWrites, 2);
        chk("bp_count", 32'(word_count), 2);

        // Misaligned, out-of-window and good beats.
        startLoad();
        dutWrites = 0;
        beat(32'h6, 32'hDEAD_0006, 0);
        beat(32'h100, 32'hDEAD_0100, 0);
        beat(32'hC, 32'hBEEF_000C, 1);
        repeat (3) cyc();
        #2 chk("err_align_set", err_align, 1);
        chk("err_range_set", err_range, 1);
        chk("err_count", 32'(word_count), 1);
        chk("err_writes", dutWrites, 1);

        // Overflow: the 65th beat meets host_ready=0.
        startLoad();
        dutWrites = 0;
        for (int i = 0; i < MAXW + 1; i++) beat(BASE + 32'(4 * i), $urandom, 0);
        repeat (2) cyc();
        #2 chk("ovf_writes", dutWrites, MAXW);
        chk("ovf_count", 32'(word_count), MAXW);
        chk("ovf_done", done, 1);

        // RUN pass-through, then a restart.
        clearNext(); nCmw = 1; nCa = 32'h10; nCw = 32'h55; nCs = 3'b000;
        cyc();
        clearNext(); nSt = 1; cyc();
        clearNext(); cyc();
        #2 chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_count", 32'(word_count), 0);

        // Reset while a beat is handshaking.
        beat(32'h6, 32'h0, 0);
        dutWrites = 0;
        clearNext(); nRst = 1; nHv = 1; nHa = 32'h0; nHd = 32'hCAFE_0000;
        cyc();
        clearNext(); cyc();
        #2 chk("rst_writes", dutWrites, 0);
        chk("rst_err_align", err_align, 0);
        chk("rst_busy", busy, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            clearNext();
            nRst = ($urandom_range(0, 149) == 0);
            nSt  = ($urandom_range(0, 14) == 0);
            nHv  = ($urandom_range(0, 2) != 0);
            nHl  = ($urandom_range(0, 19) == 0);
            nHd  = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       nHa = BASE + 32'(4 * $urandom_range(0, MAXW - 1));
            else if (r == 7) nHa = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            else if (r == 8) nHa = BASE + 32'(4 * MAXW) + 32'(4 * $urandom_range(0, 1000));
            else             nHa = 32'hFFFF_FFFC;
            nCmw = $urandom_range(0, 1); nCs = 3'($urandom_range(0, 7));
            nCa = $urandom; nCw = $urandom;
            cyc();
        end
        clearNext();
        #2;
        for (int i = 0; i < MAXW; i++) chk("mem_word", dutMem[i], expMem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
